ahb_gpio_arbiter: RTL and testbench
===================================

AHB_GPIO_ARBITER -- requirements
Module: ahb_gpio_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, max HREADYOUT-low cycles in data phase before abort (range 1..255).
REQ-002 HCLK  in  1  single clock; all state changes on rising edge.
REQ-003 HRESET  in  1  reset, synchronous, active-high.
REQ-004 REQ0, REQ1  in  1 each  requester transaction request, level, held until matching DONE.
REQ-005 WR0, WR1  in  1 each  1 = write, 0 = read.
REQ-006 ADDR0, ADDR1  in  32 each  target address in GPIO slave.
REQ-007 WDATA0, WDATA1  in  32 each  write data.
REQ-008 DONE0, DONE1  out  1 each  one-cycle completion pulse to requester.
REQ-009 ERR  out  1  one-cycle pulse, coincident with DONEx, on timeout or slave PARITYERR.
REQ-010 RDATA  out  32  read data from last completed read; held until next read completes.
REQ-011 HSEL, HWRITE  out  1 each; HTRANS out 2; HADDR, HWDATA out 32; HREADY out 1 -- AHB-Lite master side to GPIO slave.
REQ-012 HREADYOUT  in  1; HRDATA  in  32; PARITYERR  in  1 -- GPIO slave responses.

Function
REQ-013 FSM states: IDLE, ADDR, DATA, DONE; all AHB outputs registered, driven from state and latched request.
REQ-014 IDLE: if any REQx high, SHALL latch grant index, WRx, ADDRx, WDATAx and move to ADDR; else stay.
REQ-015 Arbitration round-robin: both requesting -> grant the requester not granted last; single request -> grant it regardless of pointer.
REQ-016 Round-robin pointer updates only on entering DONE (including aborted transfers); reset value points at requester 1, so requester 0 wins first contention.
REQ-017 ADDR (one cycle): HSEL=1, HTRANS=2'b10, HADDR=latched addr, HWRITE=latched wr; then DATA.
REQ-018 DATA: HSEL=0, HTRANS=2'b00, HWDATA=latched wdata; HADDR/HWRITE hold values; leaves when HREADYOUT=1 sampled, or on timeout.
REQ-019 Completing read: RDATA <= HRDATA at the edge HREADYOUT=1 sampled; writes leave RDATA unchanged.
REQ-020 Wait counter: cleared on entering DATA, increments each DATA cycle with HREADYOUT=0; reaching TIMEOUT -> DONE with error flagged, RDATA unchanged.
REQ-021 PARITYERR=1 sampled with HREADYOUT=1 in DATA -> error flagged; RDATA still updated for reads.
REQ-022 DONE (one cycle): DONEx=1 for granted requester only, ERR=1 if error flagged; then IDLE.
REQ-023 HREADY output SHALL be 1 at all times except during reset, where it is 1 as well (single slave, no other master).
REQ-024 Zero-wait latency: REQx sampled high at edge k -> ADDR in cycle k..k+1, DATA k+1..k+2, DONEx high k+2..k+3; minimum 4 cycles per transaction including IDLE.
REQ-025 Request drop mid-transaction: REQx falling after grant SHALL NOT abort; transfer completes and DONEx still pulses.
REQ-026 Non-granted requester's REQ/WR/ADDR/WDATA changes during a transfer SHALL have no effect on the bus.
REQ-027 DONE0 and DONE1 SHALL never be high in the same cycle.

Reset
REQ-028 HRESET=1 at a rising edge: state=IDLE, pointer=1, counter=0, error flag=0 next cycle.
REQ-029 Reset values: HSEL=0, HTRANS=2'b00, HWRITE=0, HADDR=0, HWDATA=0, HREADY=1, DONE0=DONE1=0, ERR=0, RDATA=0.
REQ-030 Reset mid-transaction (ADDR or DATA) SHALL abort without DONE/ERR pulse; requester must re-request.

Verification
REQ-031 REQ0=1, WR0=1, ADDR0=0x0000_0004, WDATA0=0x0000_FFFF, HREADYOUT=1 -> one NONSEQ write at 0x04, HWDATA=0x0000_FFFF in data phase, DONE0 2 cycles after address phase start, ERR=0.
REQ-032 REQ0 and REQ1 asserted same cycle after reset, both reads -> requester 0 served first, then requester 1; DONE0 precedes DONE1 by 4 cycles.
REQ-033 REQ1 read at 0x00, slave holds HREADYOUT=0 for 3 cycles, HRDATA=0x0000_00A5 -> DONE1 after 3 wait cycles, RDATA=0x0000_00A5, ERR=0.
REQ-034 HREADYOUT held 0 with TIMEOUT=16 -> DONEx and ERR pulse together after 16 DATA cycles; RDATA unchanged; next request proceeds normally.
REQ-035 Read completing with PARITYERR=1 -> DONEx and ERR=1, RDATA=HRDATA.
REQ-036 HRESET asserted during DATA -> all outputs at REQ-029 values next cycle, no DONE pulse, pointer back to 1.

Source files
------------

// File: rtl/ahb_gpio_arbiter.sv
// ahb_gpio_arbiter: two-requester round-robin front end driving a single
// AHB-Lite GPIO slave.
// Handshake: a requester raises REQx with WRx/ADDRx/WDATAx stable and holds it
// until DONEx pulses for one cycle. ERR pulses together with DONEx when the
// transfer timed out or the slave reported a parity error. The request fields
// are captured only in IDLE, so later changes on them have no effect on the
// transfer already in flight.
module ahb_gpio_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic        WR0,
   input  logic        WR1,
   input  logic [31:0] ADDR0,
   input  logic [31:0] ADDR1,
   input  logic [31:0] WDATA0,
   input  logic [31:0] WDATA1,
   output logic        DONE0,
   output logic        DONE1,
   output logic        ERR,
   output logic [31:0] RDATA,
   output logic        HSEL,
   output logic        HWRITE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic        HREADY,
   input  logic        HREADYOUT,
   input  logic [31:0] HRDATA,
   input  logic        PARITYERR,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state;
   logic        grant;       // requester owning the current transfer
   logic        last_grant;  // round-robin pointer: last requester served
   logic        lat_wr;
   logic [31:0] lat_wdata;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_inc;
   logic        pick;

   // Only one slave and one master exist, so the bus is always ready.
   assign HREADY    = 1'b1;
   assign fsm_state = state;
   assign wait_inc  = wait_cnt + 8'd1;

   // Round-robin choice: contention goes to the requester not served last.
   always_comb begin
      pick = 1'b0;
      if (REQ0 && REQ1) begin
         pick = ~last_grant;
      end else if (REQ1) begin
         pick = 1'b1;
      end
   end

   // Transfer sequencer; every bus and requester output is registered here.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state      <= ST_IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         lat_wr     <= 1'b0;
         lat_wdata  <= 32'd0;
         wait_cnt   <= 8'd0;
         DONE0      <= 1'b0;
         DONE1      <= 1'b0;
         ERR        <= 1'b0;
         RDATA      <= 32'd0;
         HSEL       <= 1'b0;
         HWRITE     <= 1'b0;
         HTRANS     <= 2'b00;
         HADDR      <= 32'd0;
         HWDATA     <= 32'd0;
      end else begin
         DONE0 <= 1'b0;
         DONE1 <= 1'b0;
         ERR   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (REQ0 || REQ1) begin
                  grant     <= pick;
                  lat_wr    <= pick ? WR1 : WR0;
                  lat_wdata <= pick ? WDATA1 : WDATA0;
                  HSEL      <= 1'b1;
                  HTRANS    <= 2'b10;
                  HADDR     <= pick ? ADDR1 : ADDR0;
                  HWRITE    <= pick ? WR1 : WR0;
                  state     <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               HSEL     <= 1'b0;
               HTRANS   <= 2'b00;
               HWDATA   <= lat_wdata;
               wait_cnt <= 8'd0;
               state    <= ST_DATA;
            end
            ST_DATA: begin
               if (HREADYOUT) begin
                  if (!lat_wr) begin
                     RDATA <= HRDATA;
                  end
                  ERR        <= PARITYERR;
                  DONE0      <= ~grant;
                  DONE1      <= grant;
                  last_grant <= grant;
                  state      <= ST_DONE;
               end else if (wait_inc == TIMEOUT_CNT) begin
                  wait_cnt   <= wait_inc;
                  ERR        <= 1'b1;
                  DONE0      <= ~grant;
                  DONE1      <= grant;
                  last_grant <= grant;
                  state      <= ST_DONE;
               end else begin
                  wait_cnt <= wait_inc;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_gpio_arbiter.sv
// Bench for ahb_gpio_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of the arbiter.
module tb_ahb_gpio_arbiter;

   localparam int TO = 16;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        REQ0, REQ1, WR0, WR1;
   logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
   logic        DONE0, DONE1, ERR;
   logic [31:0] RDATA;
   logic        HSEL, HWRITE;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR, HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        PARITYERR;
   logic [1:0]  fsm_state;

   ahb_gpio_arbiter #(.TIMEOUT(TO)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
      .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
      .DONE0(DONE0), .DONE1(DONE1), .ERR(ERR), .RDATA(RDATA),
      .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS), .HADDR(HADDR),
      .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .PARITYERR(PARITYERR),
      .fsm_state(fsm_state)
   );

   // clock / cycle counter
   always #5 HCLK = ~HCLK;
   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   // scoreboard and model state
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   bit          last_grant;      // model round-robin pointer
   logic [31:0] model_rdata;
   logic        tb_wr[2];
   logic [31:0] tb_addr[2];
   logic [31:0] tb_wdata[2];
   int          done_cyc;

   task automatic tick();
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      check(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      tb_wr[i]    = wr;
      tb_addr[i]  = a;
      tb_wdata[i] = wd;
   endtask

   task automatic drive_reqs(input bit r0, input bit r1);
      REQ0   = r0;
      REQ1   = r1;
      WR0    = tb_wr[0];
      WR1    = tb_wr[1];
      ADDR0  = tb_addr[0];
      ADDR1  = tb_addr[1];
      WDATA0 = tb_wdata[0];
      WDATA1 = tb_wdata[1];
   endtask

   task automatic check_reset_vals(input string tag);
      check1({tag, "_hsel"}, HSEL, 1'b0);
      check({tag, "_htrans"}, 32'(HTRANS), 32'd0);
      check1({tag, "_hwrite"}, HWRITE, 1'b0);
      check({tag, "_haddr"}, HADDR, 32'd0);
      check({tag, "_hwdata"}, HWDATA, 32'd0);
      check1({tag, "_hready"}, HREADY, 1'b1);
      check1({tag, "_done0"}, DONE0, 1'b0);
      check1({tag, "_done1"}, DONE1, 1'b0);
      check1({tag, "_err"}, ERR, 1'b0);
      check({tag, "_rdata"}, RDATA, 32'd0);
   endtask

   // One complete transaction, starting and ending at an IDLE-cycle negedge.
   // n_wait: cycles the slave keeps HREADYOUT low; >= TO means it never answers.
   task automatic do_txn(input bit r0, input bit r1, input int n_wait,
                         input logic [31:0] rd, input bit par, input bit chaos);
      int          g;
      int          dcyc;
      bit          exp_err;
      logic [31:0] exp_rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      g  = (r0 && r1) ? (last_grant ? 0 : 1) : (r1 ? 1 : 0);
      wr = tb_wr[g];
      a  = tb_addr[g];
      wd = tb_wdata[g];
      if (n_wait >= TO) begin
         dcyc    = TO;
         exp_err = 1'b1;
         exp_rd  = model_rdata;
      end else begin
         dcyc    = n_wait + 1;
         exp_err = par;
         exp_rd  = wr ? model_rdata : rd;
      end
      exp_q.push_back(exp_rd);

      drive_reqs(r0, r1);
      HREADYOUT = 1'b0;
      PARITYERR = 1'b0;
      tick();
      // address phase
      check1("a_hsel", HSEL, 1'b1);
      check("a_htrans", 32'(HTRANS), 32'd2);
      check("a_haddr", HADDR, a);
      check1("a_hwrite", HWRITE, wr);
      check1("a_done0", DONE0, 1'b0);
      check1("a_done1", DONE1, 1'b0);
      if (chaos) begin
         if (g == 0) begin
            REQ1 = 1'($urandom_range(0, 1)); WR1 = 1'($urandom_range(0, 1));
            ADDR1 = $urandom; WDATA1 = $urandom;
            if ($urandom_range(0, 1) == 1) REQ0 = 1'b0;
         end else begin
            REQ0 = 1'($urandom_range(0, 1)); WR0 = 1'($urandom_range(0, 1));
            ADDR0 = $urandom; WDATA0 = $urandom;
            if ($urandom_range(0, 1) == 1) REQ1 = 1'b0;
         end
      end
      tick();
      // data phase
      for (int c = 1; c <= dcyc; c++) begin
         check1("d_hsel", HSEL, 1'b0);
         check("d_htrans", 32'(HTRANS), 32'd0);
         check("d_hwdata", HWDATA, wd);
         check("d_haddr", HADDR, a);
         check1("d_hwrite", HWRITE, wr);
         check1("d_done0", DONE0, 1'b0);
         check1("d_done1", DONE1, 1'b0);
         check1("d_err", ERR, 1'b0);
         HREADYOUT = (c == n_wait + 1);
         HRDATA    = HREADYOUT ? rd : $urandom;
         PARITYERR = HREADYOUT ? par : 1'($urandom_range(0, 1));
         tick();
      end
      // completion cycle
      done_cyc = cyc;
      check1("c_done0", DONE0, g == 0);
      check1("c_done1", DONE1, g == 1);
      check1("c_err", ERR, exp_err);
      check("c_rdata", RDATA, exp_q.pop_front());
      model_rdata = exp_rd;
      last_grant  = (g == 1);
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      HREADYOUT = 1'b0;
      PARITYERR = 1'b0;
      tick();
      // back in idle
      check1("i_done0", DONE0, 1'b0);
      check1("i_done1", DONE1, 1'b0);
      check1("i_err", ERR, 1'b0);
      check1("i_hsel", HSEL, 1'b0);
      check("i_rdata", RDATA, model_rdata);
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // directed and random stimulus
   initial begin
      int d0;
      HRESET = 1'b1;
      HREADYOUT = 1'b0;
      HRDATA = 32'd0;
      PARITYERR = 1'b0;
      set_req(0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 32'd0, 32'd0);
      drive_reqs(1'b0, 1'b0);
      last_grant  = 1'b1;
      model_rdata = 32'd0;
      tick();
      tick();
      check_reset_vals("rst");
      HRESET = 1'b0;

      // single zero-wait write from requester 0
      set_req(0, 1'b1, 32'h0000_0004, 32'h0000_FFFF);
      do_txn(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);

      // contention: 0 first, then 1 exactly four cycles later
      set_req(0, 1'b0, 32'h0000_0010, 32'h0);
      set_req(1, 1'b0, 32'h0000_0020, 32'h0);
      do_txn(1'b1, 1'b1, 0, 32'h1111_0000, 1'b0, 1'b0);
      d0 = done_cyc;
      do_txn(1'b1, 1'b1, 0, 32'h2222_0000, 1'b0, 1'b0);
      check("rr_gap", 32'(done_cyc - d0), 32'd4);

      // requester 1 read with three wait states
      set_req(1, 1'b0, 32'h0000_0000, 32'h0);
      do_txn(1'b0, 1'b1, 3, 32'h0000_00A5, 1'b0, 1'b0);

      // slave never answers: timeout, RDATA kept, then a normal transfer
      set_req(0, 1'b0, 32'h0000_0008, 32'h0);
      do_txn(1'b1, 1'b0, TO + 5, 32'hDEAD_BEEF, 1'b0, 1'b0);
      set_req(1, 1'b1, 32'h0000_000C, 32'hCAFE_0001);
      do_txn(1'b0, 1'b1, 0, 32'h0, 1'b0, 1'b0);

      // slave answers on the last cycle before timeout
      set_req(1, 1'b0, 32'h0000_0014, 32'h0);
      do_txn(1'b0, 1'b1, TO - 1, 32'h0BAD_F00D, 1'b0, 1'b0);

      // read with parity error still updates RDATA
      set_req(0, 1'b0, 32'h0000_0018, 32'h0);
      do_txn(1'b1, 1'b0, 1, 32'h5A5A_1234, 1'b1, 1'b0);

      // reset during data phase aborts silently and restores the pointer
      set_req(0, 1'b1, 32'h0000_0040, 32'h1234_5678);
      drive_reqs(1'b1, 1'b0);
      tick();
      check1("ra_hsel", HSEL, 1'b1);
      tick();
      check("ra_hwdata", HWDATA, 32'h1234_5678);
      HRESET = 1'b1;
      tick();
      check_reset_vals("mid_rst");
      HRESET = 1'b0;
      REQ0 = 1'b0;
      tick();
      check1("post_rst_done0", DONE0, 1'b0);
      check1("post_rst_err", ERR, 1'b0);
      last_grant  = 1'b1;
      model_rdata = 32'd0;
      set_req(0, 1'b0, 32'h0000_0044, 32'h0);
      set_req(1, 1'b0, 32'h0000_0048, 32'h0);
      do_txn(1'b1, 1'b1, 0, 32'h7777_8888, 1'b0, 1'b0);

      // randomized traffic with request drops and non-granted input noise
      for (int i = 0; i < 40; i++) begin
         int          r;
         int          n;
         logic [31:0] rd;
         bit          par;
         r = $urandom_range(1, 3);
         set_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
         set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
         n = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
         par = ($urandom_range(0, 7) == 0);
         rd = $urandom;
         do_txn(r[0], r[1], n, rd, par, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
